// File: rtl/pipe_hazard_ctrl.sv
// Hazard, stall and flush controller for the five-stage pipeline: per-cycle
// register enables and bubble controls, halt drain sequencing and a stall counter.
module pipe_hazard_ctrl #(
   parameter int DRAIN_CYC = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   input  logic        id_rs_en,
   input  logic        id_rt_en,
   input  logic [2:0]  id_rs,
   input  logic [2:0]  id_rt,
   input  logic        id_halt,
   input  logic        idex_memread,
   input  logic        idex_regwrite,
   input  logic [2:0]  idex_wreg,
   input  logic        ex_redirect,
   input  logic        imem_stall,
   input  logic        dmem_stall,
   output logic        pc_we,
   output logic        ifid_we,
   output logic        ifid_nop,
   output logic        idex_nop,
   output logic        back_we,
   output logic        halted,
   output logic [15:0] stall_cnt
);

   localparam int CW = (DRAIN_CYC < 1) ? 1 : $clog2(DRAIN_CYC + 1);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t          state_r;
   logic [CW-1:0]   drain_cnt_r;
   logic [15:0]     stall_cnt_r;
   logic            lu_s;
   logic            take_halt_s;
   logic            stall_any_s;

   // R0 is an ordinary register here, so no zero-register exclusion.
   assign lu_s = id_valid && idex_memread && idex_regwrite &&
                 ((id_rs_en && (id_rs == idex_wreg)) ||
                  (id_rt_en && (id_rt == idex_wreg)));

   assign stall_any_s = (state_r != HALTED) && (!pc_we || idex_nop || !back_we);
   assign stall_cnt   = stall_cnt_r;

   // Enable and bubble decode from current state and hazard inputs.
   always_comb begin
      pc_we       = 1'b1;
      ifid_we     = 1'b1;
      ifid_nop    = 1'b0;
      idex_nop    = 1'b0;
      back_we     = 1'b1;
      halted      = 1'b0;
      take_halt_s = 1'b0;
      case (state_r)
         RUN: begin
            if (dmem_stall) begin
               pc_we    = 1'b0;
               ifid_we  = 1'b0;
               back_we  = 1'b0;
            end else if (ex_redirect) begin
               ifid_nop = 1'b1;
               idex_nop = 1'b1;
            end else if (lu_s) begin
               pc_we    = 1'b0;
               ifid_we  = 1'b0;
               idex_nop = 1'b1;
            end else if (id_halt && id_valid) begin
               pc_we       = 1'b0;
               take_halt_s = 1'b1;
            end else if (imem_stall) begin
               pc_we    = 1'b0;
               ifid_nop = 1'b1;
            end else begin
               pc_we    = 1'b1;
               ifid_we  = 1'b1;
            end
         end
         DRAIN: begin
            // The halt is the oldest live instruction, so redirects are moot.
            pc_we    = 1'b0;
            ifid_nop = 1'b1;
            idex_nop = 1'b1;
            back_we  = !dmem_stall;
         end
         HALTED: begin
            pc_we    = 1'b0;
            ifid_we  = 1'b0;
            ifid_nop = 1'b1;
            idex_nop = 1'b1;
            back_we  = 1'b0;
            halted   = 1'b1;
         end
         default: begin
            pc_we    = 1'b0;
            ifid_we  = 1'b0;
            ifid_nop = 1'b1;
            idex_nop = 1'b1;
            back_we  = 1'b0;
            halted   = 1'b1;
         end
      endcase
   end

   // Run / drain / halted sequencing with the drain countdown.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= RUN;
         drain_cnt_r <= {CW{1'b0}};
      end else begin
         case (state_r)
            RUN: begin
               if (take_halt_s) begin
                  state_r     <= DRAIN;
                  drain_cnt_r <= CW'(DRAIN_CYC);
               end else begin
                  state_r     <= RUN;
               end
            end
            DRAIN: begin
               if (back_we) begin
                  if (drain_cnt_r <= CW'(1)) begin
                     state_r     <= HALTED;
                     drain_cnt_r <= {CW{1'b0}};
                  end else begin
                     drain_cnt_r <= drain_cnt_r - CW'(1);
                  end
               end else begin
                  drain_cnt_r <= drain_cnt_r;
               end
            end
            HALTED: begin
               state_r <= HALTED;
            end
            default: begin
               state_r     <= RUN;
               drain_cnt_r <= {CW{1'b0}};
            end
         endcase
      end
   end

   // Saturating count of cycles that lost a pipeline slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_r <= 16'd0;
      end else if (stall_any_s && (stall_cnt_r != 16'hFFFF)) begin
         stall_cnt_r <= stall_cnt_r + 16'd1;
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed, table-driven bench for pipe_hazard_ctrl with hand-written
// sequences for freeze, halt drain, mid-drain reset and counter saturation.
module tb_pipe_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid, id_rs_en, id_rt_en, id_halt;
   logic [2:0]  id_rs, id_rt, idex_wreg;
   logic        idex_memread, idex_regwrite, ex_redirect, imem_stall, dmem_stall;
   logic        pc_we, ifid_we, ifid_nop, idex_nop, back_we, halted;
   logic [15:0] stall_cnt;

   int errors = 0;
   int checks = 0;
   logic [15:0] exp_cnt;

   pipe_hazard_ctrl #(.DRAIN_CYC(3)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_en(id_rs_en),
      .id_rt_en(id_rt_en), .id_rs(id_rs), .id_rt(id_rt), .id_halt(id_halt),
      .idex_memread(idex_memread), .idex_regwrite(idex_regwrite),
      .idex_wreg(idex_wreg), .ex_redirect(ex_redirect), .imem_stall(imem_stall),
      .dmem_stall(dmem_stall), .pc_we(pc_we), .ifid_we(ifid_we),
      .ifid_nop(ifid_nop), .idex_nop(idex_nop), .back_we(back_we),
      .halted(halted), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   // inputs: valid rs_en rt_en rs rt memread regwrite wreg redirect imem dmem
   // expected outputs packed {pc_we, ifid_we, ifid_nop, idex_nop, back_we}
   typedef struct {
      string      name;
      logic       v, rse, rte;
      logic [2:0] rs, rt;
      logic       mr, rw;
      logic [2:0] wr;
      logic       redir, imem, dmem;
      logic [4:0] exp;
   } vec_t;

   vec_t vecs[15];

   function automatic logic [4:0] outs();
      return {pc_we, ifid_we, ifid_nop, idex_nop, back_we};
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_idle();
      id_valid = 1'b0; id_rs_en = 1'b0; id_rt_en = 1'b0; id_halt = 1'b0;
      id_rs = 3'd0; id_rt = 3'd0; idex_wreg = 3'd0;
      idex_memread = 1'b0; idex_regwrite = 1'b0;
      ex_redirect = 1'b0; imem_stall = 1'b0; dmem_stall = 1'b0;
   endtask

   task automatic apply(input vec_t t);
      id_valid = t.v; id_rs_en = t.rse; id_rt_en = t.rte;
      id_rs = t.rs; id_rt = t.rt; id_halt = 1'b0;
      idex_memread = t.mr; idex_regwrite = t.rw; idex_wreg = t.wr;
      ex_redirect = t.redir; imem_stall = t.imem; dmem_stall = t.dmem;
   endtask

   task automatic do_reset();
      set_idle();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Load-use pattern used by several sequences.
   task automatic set_lu();
      set_idle();
      id_valid = 1'b1; id_rs_en = 1'b1; id_rs = 3'd3;
      idex_memread = 1'b1; idex_regwrite = 1'b1; idex_wreg = 3'd3;
   endtask

   initial begin
      vecs[0]  = '{"idle",        1'b0,1'b0,1'b0,3'd0,3'd0,1'b0,1'b0,3'd0,1'b0,1'b0,1'b0,5'b11001};
      vecs[1]  = '{"lu_rs",       1'b1,1'b1,1'b0,3'd3,3'd0,1'b1,1'b1,3'd3,1'b0,1'b0,1'b0,5'b00011};
      vecs[2]  = '{"rs_en_off",   1'b1,1'b0,1'b0,3'd3,3'd0,1'b1,1'b1,3'd3,1'b0,1'b0,1'b0,5'b11001};
      vecs[3]  = '{"lu_rt",       1'b1,1'b0,1'b1,3'd1,3'd5,1'b1,1'b1,3'd5,1'b0,1'b0,1'b0,5'b00011};
      vecs[4]  = '{"lu_r0",       1'b1,1'b1,1'b0,3'd0,3'd7,1'b1,1'b1,3'd0,1'b0,1'b0,1'b0,5'b00011};
      vecs[5]  = '{"no_regwrite", 1'b1,1'b1,1'b0,3'd3,3'd0,1'b1,1'b0,3'd3,1'b0,1'b0,1'b0,5'b11001};
      vecs[6]  = '{"no_memread",  1'b1,1'b1,1'b0,3'd3,3'd0,1'b0,1'b1,3'd3,1'b0,1'b0,1'b0,5'b11001};
      vecs[7]  = '{"id_invalid",  1'b0,1'b1,1'b1,3'd3,3'd3,1'b1,1'b1,3'd3,1'b0,1'b0,1'b0,5'b11001};
      vecs[8]  = '{"rs_mismatch", 1'b1,1'b1,1'b1,3'd2,3'd4,1'b1,1'b1,3'd3,1'b0,1'b0,1'b0,5'b11001};
      vecs[9]  = '{"redir_lu",    1'b1,1'b1,1'b0,3'd3,3'd0,1'b1,1'b1,3'd3,1'b1,1'b0,1'b0,5'b11111};
      vecs[10] = '{"dmem_lu",     1'b1,1'b1,1'b0,3'd3,3'd0,1'b1,1'b1,3'd3,1'b0,1'b0,1'b1,5'b00000};
      vecs[11] = '{"imem",        1'b0,1'b0,1'b0,3'd0,3'd0,1'b0,1'b0,3'd0,1'b0,1'b1,1'b0,5'b01101};
      vecs[12] = '{"lu_imem",     1'b1,1'b1,1'b0,3'd3,3'd0,1'b1,1'b1,3'd3,1'b0,1'b1,1'b0,5'b00011};
      vecs[13] = '{"redir_imem",  1'b0,1'b0,1'b0,3'd0,3'd0,1'b0,1'b0,3'd0,1'b1,1'b1,1'b0,5'b11111};
      vecs[14] = '{"dmem_redir",  1'b0,1'b0,1'b0,3'd0,3'd0,1'b0,1'b0,3'd0,1'b1,1'b0,1'b1,5'b00000};

      // Reset values, checked while reset is held.
      set_idle();
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk("rst_outs", 16'(outs()), 16'(5'b11001));
      chk("rst_halted", 16'(halted), 16'd0);
      chk("rst_cnt", stall_cnt, 16'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1;
      chk("post_rst_outs", 16'(outs()), 16'(5'b11001));
      chk("post_rst_cnt", stall_cnt, 16'd0);

      // Table-driven single-cycle vectors, all in RUN.
      exp_cnt = 16'd0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         apply(vecs[i]);
         #1;
         chk({"outs_", vecs[i].name}, 16'(outs()), 16'(vecs[i].exp));
         chk({"cnt_", vecs[i].name}, stall_cnt, exp_cnt);
         chk({"halted_", vecs[i].name}, 16'(halted), 16'd0);
         if (!vecs[i].exp[4] || vecs[i].exp[1] || !vecs[i].exp[0]) exp_cnt = exp_cnt + 16'd1;
      end
      @(negedge clk);
      set_idle();
      #1;
      chk("table_cnt_total", stall_cnt, exp_cnt);

      // Dmem freeze for 4 cycles over a pending load-use, then one bubble.
      do_reset();
      set_lu();
      dmem_stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("freeze_outs", 16'(outs()), 16'(5'b00000));
         @(negedge clk);
      end
      dmem_stall = 1'b0;
      #1;
      chk("freeze_lu_bubble", 16'(outs()), 16'(5'b00011));
      @(negedge clk);
      idex_memread = 1'b0;
      #1;
      chk("freeze_lu_cleared", 16'(outs()), 16'(5'b11001));
      chk("freeze_cnt", stall_cnt, 16'd5);

      // Halt drain with a 2-cycle dmem stall mid-drain.
      do_reset();
      id_valid = 1'b1; id_halt = 1'b1;
      #1;
      chk("halt_capture", 16'(outs()), 16'(5'b01001));
      @(negedge clk);
      set_idle();
      for (int i = 0; i < 5; i++) begin
         dmem_stall = (i == 1 || i == 2) ? 1'b1 : 1'b0;
         ex_redirect = (i == 3) ? 1'b1 : 1'b0;
         #1;
         chk("drain_halted", 16'(halted), 16'd0);
         chk("drain_outs", 16'(outs()), dmem_stall ? 16'(5'b01110) : 16'(5'b01111));
         @(negedge clk);
      end
      set_idle();
      #1;
      chk("halted_rise", 16'(halted), 16'd1);
      chk("halted_outs", 16'(outs()), 16'(5'b00110));
      chk("halted_cnt", stall_cnt, 16'd6);
      ex_redirect = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("halted_redir_outs", 16'(outs()), 16'(5'b00110));
      chk("halted_hold", 16'(halted), 16'd1);
      chk("halted_cnt_frozen", stall_cnt, 16'd6);

      // Reset pulse mid-drain, asserted between clock edges.
      do_reset();
      id_valid = 1'b1; id_halt = 1'b1;
      @(negedge clk);
      set_idle();
      @(negedge clk);
      #1;
      chk("mid_drain_outs", 16'(outs()), 16'(5'b01111));
      #2;
      rst = 1'b1;
      #1;
      chk("rst_mid_outs", 16'(outs()), 16'(5'b11001));
      chk("rst_mid_halted", 16'(halted), 16'd0);
      chk("rst_mid_cnt", stall_cnt, 16'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("after_rst_outs", 16'(outs()), 16'(5'b11001));
      chk("after_rst_cnt", stall_cnt, 16'd0);

      // Saturation: 65540 frozen cycles.
      dmem_stall = 1'b1;
      repeat (65540) @(negedge clk);
      #1;
      chk("sat_cnt", stall_cnt, 16'hFFFF);
      @(negedge clk);
      #1;
      chk("sat_hold", stall_cnt, 16'hFFFF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard, stall and flush controller for the five-stage pipeline. Each cycle it computes write enables and nop-insert controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. Its `idex_nop` output drives the ID/EX register's `nop` input, which kills RegWrite, MemRead, MemWrite and createdump on capture. It also sequences the halt drain and keeps a saturating stall-cycle counter.

## Interface
Parameters:
- `DRAIN_CYC`, default 3: cycles a halt needs to travel from ID/EX capture to WB retirement.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `id_valid` in 1: IF/ID holds a real instruction.
- `id_rs_en` in 1: ID instruction reads rs.
- `id_rt_en` in 1: ID instruction reads rt.
- `id_rs` in 3: ID source register rs.
- `id_rt` in 3: ID source register rt.
- `id_halt` in 1: ID instruction is HALT.
- `idex_memread` in 1: ID/EX holds a load.
- `idex_regwrite` in 1: ID/EX instruction writes a register.
- `idex_wreg` in 3: ID/EX destination register.
- `ex_redirect` in 1: EX resolved a taken branch or jump this cycle.
- `imem_stall` in 1: instruction fetch not ready.
- `dmem_stall` in 1: data memory access not complete.
- `pc_we` out 1: PC update enable.
- `ifid_we` out 1: IF/ID capture enable.
- `ifid_nop` out 1: load a bubble into IF/ID.
- `idex_nop` out 1: to the ID/EX `nop` input; captured instruction is killed.
- `back_we` out 1: common capture enable for ID/EX, EX/MEM and MEM/WB.
- `halted` out 1: processor halted.
- `stall_cnt` out 16: saturating count of stall and bubble cycles.

## Operation
- Registered state:
  - FSM with states RUN, DRAIN and HALTED.
  - Drain counter, width clog2(DRAIN_CYC+1).
  - `stall_cnt`.
- All enable and nop outputs are combinational from the inputs and the state.
- **Load-use hazard (`lu`).** Asserted when all of the following hold:
  - `id_valid`, `idex_memread` and `idex_regwrite` are all 1;
  - either (`id_rs_en` and `id_rs`==`idex_wreg`) or (`id_rt_en` and `id_rt`==`idex_wreg`).
  - R0 is a normal register and is not excluded from the compare.
- **RUN-state priority**, highest first:
  1. `dmem_stall`: `pc_we`, `ifid_we` and `back_we` are 0; nop outputs are 0. The whole pipe freezes.
  2. `ex_redirect`: `pc_we`=1, `ifid_we`=1, `ifid_nop`=1, `idex_nop`=1, `back_we`=1. The two younger instructions are squashed; a halt in ID is squashed too.
  3. `lu`: `pc_we`=0, `ifid_we`=0, `idex_nop`=1, `back_we`=1. This inserts one bubble; on the next cycle the load has left ID/EX and `lu` clears.
  4. `id_halt` with `id_valid`: the halt is captured into ID/EX normally with `idex_nop`=0 and `pc_we`=0. Go to DRAIN with the counter loaded to DRAIN_CYC.
  5. `imem_stall`: `pc_we`=0, `ifid_we`=1, `ifid_nop`=1, `back_we`=1.
  6. Otherwise: `pc_we`=1, `ifid_we`=1, `back_we`=1; nop outputs are 0.
- **DRAIN:**
  - `pc_we`=0, `ifid_we`=1, `ifid_nop`=1, `idex_nop`=1.
  - `back_we` = ~`dmem_stall`.
  - The counter decrements only when `back_we`=1. When it reaches 0, go to HALTED.
  - `ex_redirect` is ignored: the halt is older than anything behind it.
- **HALTED:**
  - `halted`=1; `pc_we`, `ifid_we` and `back_we` are 0; `ifid_nop`=1 and `idex_nop`=1.
  - The state is held until `rst`.
- **`stall_cnt`:**
  - Increments by 1 on each cycle where the state is not HALTED and at least one of `pc_we`=0, `idex_nop`=1 or `back_we`=0 holds.
  - Saturates at 0xFFFF.

## Timing
- **Reset.** Asserting `rst` at any time, including mid-DRAIN or mid-stall, immediately sets state RUN, drain counter 0 and `stall_cnt` 0.
- **Outputs during reset** with idle inputs: `pc_we`=1, `ifid_we`=1, `ifid_nop`=0, `idex_nop`=0, `back_we`=1, `halted`=0.
- **Latency.**
  - Hazard, redirect and stall responses are in the same cycle: zero-cycle, combinational.
  - FSM and counter changes become visible the cycle after the triggering edge.
- **Load-use cost:** exactly 1 bubble per hazard.
- **Redirect cost:** exactly 2 squashed slots.
- **`dmem_stall` timing:**
  - An N-cycle `dmem_stall` freezes the pipe for exactly N cycles.
  - `dmem_stall` coinciding with `lu` or `ex_redirect`: the stall wins, and the hazard or redirect is re-evaluated on the first non-stalled cycle. Inputs are held by the frozen registers.
- **Halt timing:** `halted` rises DRAIN_CYC unstalled cycles after the halt is captured into ID/EX.

## Test plan
- **Reset:** assert `rst`, then release with idle inputs → all enables 1, nops 0, `halted`=0, `stall_cnt`=0.
- **Load-use:** `idex_memread`=1, `idex_regwrite`=1, `idex_wreg`=3, `id_rs_en`=1, `id_rs`=3, `id_valid`=1 → one cycle of `pc_we`=0, `ifid_we`=0, `idex_nop`=1; `stall_cnt` becomes 1. The same pattern with `id_rs_en`=0 → no stall.
- **Redirect over hazard:** `ex_redirect`=1 together with `lu` → `pc_we`=1, `ifid_nop`=1, `idex_nop`=1, `stall_cnt` +1.
- **Dmem freeze:** `dmem_stall` high for 4 cycles during a pending `lu` → 4 cycles with all enables 0, then 1 load-use bubble; `stall_cnt` +5.
- **Halt drain:** `id_halt` in RUN, then `dmem_stall` for 2 cycles mid-DRAIN → `halted` rises after 3+2 cycles. Subsequent `ex_redirect` → no output change.
- **Reset mid-DRAIN and saturation:**
  - Pulse `rst` mid-DRAIN → RUN, `halted`=0, `stall_cnt`=0.
  - Force 65540 stall cycles → `stall_cnt`=0xFFFF.
